// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - SRAM access sequencer between datapath MAR/MDR and external SRAM
// Optional MEM_IO_MAP_EN: address 16'hFFFF maps to switches (read) and HEX_DATA (write).
module mem_access_ctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [9:0]  SW,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        Busy,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic [15:0] HEX_DATA
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_ACC,
    DONE,
    HOLD
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] mar_q;
  logic [15:0] mdr_q;
  logic [15:0] mdr_in_q;
  logic        r_q;
  logic        busy_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        io_hit;

`ifdef MEM_IO_MAP_EN
  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  logic [15:0] hex_q;

  assign io_hit = (MAR == IO_ADDR);

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      hex_q <= '0;
    end else if (state_q == IDLE && Mem_WE && io_hit) begin
      hex_q <= MDR;
    end
  end

  assign HEX_DATA = hex_q;
`else
  assign io_hit   = 1'b0;
  assign HEX_DATA = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      mdr_in_q <= '0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Write wins when both requests are raised together.
          if (Mem_WE) begin
            mar_q  <= MAR;
            mdr_q  <= MDR;
            busy_q <= 1'b1;
            if (io_hit) begin
              state_q <= DONE;
              r_q     <= 1'b1;
            end else begin
              cnt_q   <= WS_LOAD;
              state_q <= WR_ACC;
              ce_n_q  <= 1'b0;
              we_n_q  <= 1'b0;
            end
          end else if (Mem_OE) begin
            mar_q  <= MAR;
            busy_q <= 1'b1;
            if (io_hit) begin
              mdr_in_q <= {6'b0, SW};
              state_q  <= DONE;
              r_q      <= 1'b1;
            end else begin
              cnt_q   <= WS_LOAD;
              state_q <= RD_ACC;
              ce_n_q  <= 1'b0;
              oe_n_q  <= 1'b0;
            end
          end
        end

        RD_ACC: begin
          if (cnt_q == 4'd0) begin
            mdr_in_q <= Data_from_SRAM;
            state_q  <= DONE;
            r_q      <= 1'b1;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        WR_ACC: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            r_q     <= 1'b1;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        DONE: begin
          state_q <= HOLD;
        end

        // A request held across several control states must not re-trigger.
        HOLD: begin
          if (!Mem_OE && !Mem_WE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign MDR_In       = mdr_in_q;
  assign R            = r_q;
  assign Busy         = busy_q;
  assign ADDR         = {4'b0, mar_q};
  assign Data_to_SRAM = mdr_q;
  assign CE_N         = ce_n_q;
  assign OE_N         = oe_n_q;
  assign WE_N         = we_n_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset_ah = 1'b1;
  logic [15:0] MAR = '0;
  logic [15:0] MDR = '0;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [9:0]  SW = '0;
  logic [15:0] Data_from_SRAM = '0;
  logic [15:0] MDR_In;
  logic        R;
  logic        Busy;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic [15:0] HEX_DATA;

  typedef struct {
    logic [15:0] mdr_in;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        io;
    int          r_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_mdr_in = '0;

  mem_access_ctrl #(.WAIT_STATES(WS)) dut (
    .Clk(Clk),
    .Reset_ah(Reset_ah),
    .MAR(MAR),
    .MDR(MDR),
    .Mem_OE(Mem_OE),
    .Mem_WE(Mem_WE),
    .SW(SW),
    .Data_from_SRAM(Data_from_SRAM),
    .MDR_In(MDR_In),
    .R(R),
    .Busy(Busy),
    .ADDR(ADDR),
    .Data_to_SRAM(Data_to_SRAM),
    .CE_N(CE_N),
    .OE_N(OE_N),
    .WE_N(WE_N),
    .HEX_DATA(HEX_DATA)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Completion monitor: every R pulse must match the oldest outstanding access.
  always @(negedge Clk) begin
    if (R === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_r", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("r_cycle", cyc, mon_e.r_cyc);
        check("mdr_in_at_r", MDR_In, mon_e.mdr_in);
        if (!mon_e.io) begin
          check("addr_at_r", ADDR, mon_e.addr);
          if (mon_e.wr) check("wdata_at_r", Data_to_SRAM, mon_e.wdata);
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle;
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    for (int i = 0; i < 8 && Busy !== 1'b0; i++) tick();
    check("return_idle", Busy, 0);
  endtask

  task automatic run_access(input logic wr, input logic [15:0] mar, input logic [15:0] mdr,
                            input logic [15:0] sram, input logic poke_mar, input int hold_extra);
    exp_t e;
    logic act;
    MAR = mar;
    MDR = mdr;
    Data_from_SRAM = sram;
    Mem_WE = wr;
    Mem_OE = !wr;
    check("busy_at_req", Busy, 0);
    if (!wr) model_mdr_in = sram;
    e.mdr_in = model_mdr_in;
    e.addr   = {4'h0, mar};
    e.wdata  = mdr;
    e.wr     = wr;
    e.io     = 1'b0;
    e.r_cyc  = cyc + WS + 2;
    sb.push_back(e);
    for (int k = 1; k <= WS + 2; k++) begin
      tick();
      if (poke_mar && k == 2) MAR = 16'h0000;
      act = (k <= WS + 1);
      check("ce_n", CE_N, !act);
      if (wr) begin
        check("we_n", WE_N, !act);
        check("oe_n_wr", OE_N, 1);
        check("wdata", Data_to_SRAM, mdr);
      end else begin
        check("oe_n", OE_N, !act);
        check("we_n_rd", WE_N, 1);
      end
      check("r", R, (k == WS + 2));
      check("busy", Busy, 1);
      check("addr", ADDR, {4'h0, mar});
    end
    for (int k = 0; k < hold_extra; k++) begin
      tick();
      check("hold_r", R, 0);
      check("hold_ce_n", CE_N, 1);
      check("hold_busy", Busy, 1);
    end
    wait_idle();
  endtask

`ifdef MEM_IO_MAP_EN
  task automatic run_io(input logic wr, input logic [15:0] mdr, input logic [9:0] sw);
    exp_t e;
    MAR = 16'hFFFF;
    MDR = mdr;
    SW = sw;
    Mem_WE = wr;
    Mem_OE = !wr;
    if (!wr) model_mdr_in = {6'b0, sw};
    e.mdr_in = model_mdr_in;
    e.addr   = '0;
    e.wdata  = '0;
    e.wr     = wr;
    e.io     = 1'b1;
    e.r_cyc  = cyc + 1;
    sb.push_back(e);
    tick();
    check("io_r", R, 1);
    check("io_ce_n", CE_N, 1);
    check("io_oe_n", OE_N, 1);
    check("io_we_n", WE_N, 1);
    if (wr) check("hex_data", HEX_DATA, mdr);
    else    check("io_mdr_in", MDR_In, {6'b0, sw});
    wait_idle();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset_ah = 1'b1;
    tick();
    tick();
    Reset_ah = 1'b0;
    repeat (5) tick();
    check("rst_ce_n", CE_N, 1);
    check("rst_oe_n", OE_N, 1);
    check("rst_we_n", WE_N, 1);
    check("rst_r", R, 0);
    check("rst_mdr_in", MDR_In, 0);
    check("rst_busy", Busy, 0);
    check("rst_addr", ADDR, 0);
    check("rst_wdata", Data_to_SRAM, 0);
    check("rst_hex", HEX_DATA, 0);

    run_access(1'b0, 16'h0030, 16'h0000, 16'hBEEF, 1'b0, 0);
    run_access(1'b1, 16'h1234, 16'h5A5A, 16'hDEAD, 1'b1, 0);
    check("mdr_in_after_wr", MDR_In, 16'hBEEF);

    run_access(1'b0, 16'h0040, 16'h0000, 16'h1357, 1'b0, 6);
    run_access(1'b0, 16'h0041, 16'h0000, 16'h2468, 1'b0, 0);

    // Both requests together: the write must win.
    MDR = 16'h7E7E;
    sb.push_back('{mdr_in: model_mdr_in, addr: 20'h00050, wdata: 16'h7E7E, wr: 1'b1, io: 1'b0, r_cyc: cyc + WS + 2});
    MAR = 16'h0050;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    tick();
    check("prio_we_n", WE_N, 0);
    check("prio_oe_n", OE_N, 1);
    repeat (WS + 1) tick();
    check("prio_r", R, 1);
    wait_idle();

    // Reset in the middle of a read.
    MAR = 16'h0060;
    Data_from_SRAM = 16'hCAFE;
    Mem_OE = 1'b1;
    tick();
    tick();
    check("mid_oe_n", OE_N, 0);
    Reset_ah = 1'b1;
    Mem_OE = 1'b0;
    tick();
    check("mid_rst_ce_n", CE_N, 1);
    check("mid_rst_oe_n", OE_N, 1);
    check("mid_rst_we_n", WE_N, 1);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_r", R, 0);
    model_mdr_in = '0;
    Reset_ah = 1'b0;
    repeat (4) tick();
    check("post_rst_mdr_in", MDR_In, model_mdr_in);
    check("post_rst_busy", Busy, 0);

`ifdef MEM_IO_MAP_EN
    run_io(1'b1, 16'h00C3, 10'h000);
    run_io(1'b0, 16'h0000, 10'h155);
    check("hex_kept", HEX_DATA, 16'h00C3);
    Reset_ah = 1'b1;
    tick();
    Reset_ah = 1'b0;
    check("hex_rst", HEX_DATA, 0);
    model_mdr_in = '0;
`else
    run_access(1'b1, 16'hFFFF, 16'h00C3, 16'h0000, 1'b0, 0);
    check("hex_tied", HEX_DATA, 0);
    run_access(1'b0, 16'hFFFF, 16'h0000, 16'h9876, 1'b0, 0);
`endif

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side stage between the control FSM / datapath and external SRAM.
- Accepts read/write requests qualified by Mem_OE/Mem_WE against the datapath's MAR/MDR.
- Sequences SRAM strobes with a programmable number of wait states, returns read data on MDR_In, and signals completion on R.
- Sits directly downstream of the MAR/MDR registers; MDR_In feeds the MDR input mux.

Parameters:
- WAIT_STATES, 2, extra SRAM access cycles beyond the first; legal range 0..15.

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset_ah  in  1  synchronous, active-high reset
- MAR  in  16  access address from datapath
- MDR  in  16  write data from datapath
- Mem_OE  in  1  read request, active high, held until R seen
- Mem_WE  in  1  write request, active high, held until R seen
- SW  in  10  board switches (I/O-mapped read source)
- Data_from_SRAM  in  16  SRAM read data
- MDR_In  out  16  read data to datapath MDR mux
- R  out  1  access-complete pulse, one cycle
- Busy  out  1  high in any state other than IDLE
- ADDR  out  20  SRAM address, {4'b0, latched MAR}
- Data_to_SRAM  out  16  SRAM write data (latched MDR)
- CE_N, OE_N, WE_N  out  1 each  SRAM strobes, active low
- HEX_DATA  out  16  I/O-mapped display register

Behaviour:
- Interface: one clock (Clk); Reset_ah is synchronous and active-high.
- Reset values: state IDLE, R=0, Busy=0, MDR_In=0, ADDR=0, Data_to_SRAM=0, CE_N=OE_N=WE_N=1, HEX_DATA=0, wait counter=0.
- States: IDLE, RD_ACC, WR_ACC, DONE, HOLD.
- IDLE:
  - Mem_WE=1: latch MAR and MDR, load counter=WAIT_STATES, go to WR_ACC.
  - Mem_OE=1 only: latch MAR, load counter, go to RD_ACC.
  - Both high: write has priority.
  - Neither: stay.
- RD_ACC:
  - CE_N=0, OE_N=0, WE_N=1, ADDR from latched MAR.
  - Decrement counter each cycle. Go to DONE on the cycle counter==0, capturing Data_from_SRAM into MDR_In at that edge.
  - Occupancy: WAIT_STATES+1 cycles.
- WR_ACC:
  - CE_N=0, WE_N=0, OE_N=1, Data_to_SRAM = latched MDR.
  - Same counter rule as RD_ACC; goes to DONE.
- DONE:
  - R=1 for exactly one cycle; all strobes deasserted.
  - ADDR and Data_to_SRAM held stable (hold time). Go to HOLD.
- HOLD:
  - R=0. Wait until Mem_OE=0 and Mem_WE=0, then go to IDLE.
  - Prevents re-triggering on a request held across multiple control states.
- MAR/MDR changes after acceptance are ignored until the next IDLE acceptance.
- MDR_In keeps its last captured value until the next read completes; writes do not alter it.
- Latency: request first high in cycle 0 (IDLE), R high in cycle WAIT_STATES+2. WAIT_STATES=0 gives R in cycle 2.
- Counter width: 4 bits, no wrap; the counter is only decremented while nonzero.
- Reset mid-access: strobes deassert at the reset edge, FSM returns to IDLE, no R pulse, HEX_DATA cleared.

Optional Feature:
- Macro: MEM_IO_MAP_EN.
- Defined:
  - Address 16'hFFFF is I/O space; SRAM strobes stay deasserted for it.
  - Read of FFFF: IDLE goes directly to DONE; MDR_In = {6'b0, SW} captured at the IDLE edge; R in cycle 1.
  - Write of FFFF: HEX_DATA <= MDR at the IDLE edge, IDLE goes to DONE, R in cycle 1.
- Undefined:
  - FFFF is an ordinary SRAM address.
  - HEX_DATA is tied to 0.

Test Plan:
- Reset, then idle 5 cycles -> CE_N/OE_N/WE_N=1, R=0, MDR_In=0, Busy=0.
- WAIT_STATES=2, MAR=16'h0030, Mem_OE held, SRAM returns 16'hBEEF -> OE_N/CE_N low cycles 1-3, R=1 only in cycle 4, MDR_In=16'hBEEF, ADDR=20'h00030.
- Mem_WE with MAR=16'h1234, MDR=16'h5A5A; change MAR to 16'h0000 in cycle 2 -> WE_N low cycles 1-3, ADDR stays 20'h01234, Data_to_SRAM=16'h5A5A, R in cycle 4.
- Hold Mem_OE 6 cycles past R -> exactly one R pulse, no second access; deassert, then new request -> new access starts.
- Assert Reset_ah during RD_ACC cycle 2 -> next edge all strobes high, state IDLE, no R.
- MEM_IO_MAP_EN with MAR=16'hFFFF:
  - Write MDR=16'h00C3 -> HEX_DATA=16'h00C3, R in cycle 1, CE_N stays 1.
  - Read with SW=10'h155 -> MDR_In=16'h0155.
